// File: rtl/risc8_ctrl_pkg.sv
// Shared constants for the risc8 sequencer: opcode values, instruction field positions
// and the FSM state encoding.
package risc8_ctrl_pkg;

    localparam int unsigned OpcMsb  = 7;
    localparam int unsigned OpcLsb  = 4;
    localparam int unsigned AddrMsb = 3;

    // ALU opcodes (NOP..NOT) extended with the control-only opcodes (LDA..HLT).
    localparam logic [3:0] OpNop = 4'd0;
    localparam logic [3:0] OpAdd = 4'd1;
    localparam logic [3:0] OpSub = 4'd2;
    localparam logic [3:0] OpAnd = 4'd3;
    localparam logic [3:0] OpNot = 4'd4;
    localparam logic [3:0] OpLda = 4'd5;
    localparam logic [3:0] OpSto = 4'd6;
    localparam logic [3:0] OpJmp = 4'd7;
    localparam logic [3:0] OpSkz = 4'd8;
    localparam logic [3:0] OpHlt = 4'd9;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StSkip,
        StOprd,
        StExec,
        StStore,
        StHalt,
        StFault
    } state_e;

    function automatic logic is_mem_state(state_e st);
        return (st == StFetch) || (st == StOprd) || (st == StStore);
    endfunction

endpackage

// File: rtl/risc8_ctrl_if.sv
// Memory request/acknowledge bus between the sequencer and the memory.
interface risc8_ctrl_if;
    logic mem_rd;
    logic mem_wr;
    logic addr_sel;
    logic mem_ack;

    modport master (
        output mem_rd,
        output mem_wr,
        output addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  addr_sel,
        output mem_ack
    );
endinterface

// File: rtl/risc8_ack_timer.sv
// Counts cycles a memory strobe waits without mem_ack; tmo flags the last allowed cycle
// so the sequencer can fault on the following edge.
module risc8_ack_timer #(
    parameter int unsigned ACK_TMO = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic tmo
);
    localparam logic [7:0] TmoLast = 8'(ACK_TMO - 1);

    logic [7:0] cnt_q, cnt_d;

    // An ack on the final cycle takes priority, so tmo is masked by ack.
    assign tmo = enable && !ack && (cnt_q == TmoLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !ack && !tmo) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/risc8_ctrl.sv
// Multicycle sequencer for the 8-bit CPU: fetch, decode, operand read, execute and store,
// with an ack timeout that parks the machine in FAULT.
module risc8_ctrl
    import risc8_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TMO = 15,
    parameter int unsigned OPC_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        instr,
    input  logic              alu_zero,
    risc8_ctrl_if.master      bus,
    output logic              ir_ld,
    output logic              opnd_ld,
    output logic              pc_inc,
    output logic              pc_ld,
    output logic              acc_ld,
    output logic [OPC_W-1:0]  alu_op,
    output logic              zflag,
    output logic              halted,
    output logic              fault
);
    state_e     state_q, state_d;
    logic       zflag_q, zflag_d;
    logic       tmo;
    logic [3:0] opcode;
    logic       unused_operand;

    assign opcode         = instr[OpcMsb:OpcLsb];
    // The operand address goes straight to the datapath address mux.
    assign unused_operand = ^instr[AddrMsb:0];

    risc8_ack_timer #(
        .ACK_TMO (ACK_TMO)
    ) u_ack_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_d != state_q),
        .enable (is_mem_state(state_q)),
        .ack    (bus.mem_ack),
        .tmo    (tmo)
    );

    always_comb begin
        state_d      = state_q;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.addr_sel = 1'b0;
        ir_ld        = 1'b0;
        opnd_ld      = 1'b0;
        pc_inc       = 1'b0;
        pc_ld        = 1'b0;
        acc_ld       = 1'b0;
        alu_op       = OPC_W'(OpNop);
        halted       = 1'b0;
        fault        = 1'b0;

        unique case (state_q)
            StIdle, StHalt, StFault: begin
                halted = (state_q == StHalt);
                fault  = (state_q == StFault);
                if (start) state_d = StFetch;
            end
            StFetch: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    ir_ld   = 1'b1;
                    state_d = StDecode;
                end else if (tmo) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                pc_inc  = (opcode != OpJmp);
                pc_ld   = (opcode == OpJmp);
                state_d = StFetch;
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpLda: state_d = StOprd;
                    OpNot:                      state_d = StExec;
                    OpSto:                      state_d = StStore;
                    OpSkz:                      state_d = zflag_q ? StSkip : StFetch;
                    OpHlt:                      state_d = StHalt;
                    default:                    state_d = StFetch;
                endcase
            end
            StSkip: begin
                pc_inc  = 1'b1;
                state_d = StFetch;
            end
            StOprd: begin
                bus.mem_rd   = 1'b1;
                bus.addr_sel = 1'b1;
                if (bus.mem_ack) begin
                    opnd_ld = 1'b1;
                    state_d = StExec;
                end else if (tmo) begin
                    state_d = StFault;
                end
            end
            StExec: begin
                acc_ld  = 1'b1;
                // LDA passes the operand through the datapath mux, not the ALU.
                alu_op  = (opcode == OpLda) ? OPC_W'(OpNop) : OPC_W'(opcode);
                state_d = StFetch;
            end
            StStore: begin
                bus.mem_wr   = 1'b1;
                bus.addr_sel = 1'b1;
                if (bus.mem_ack) begin
                    state_d = StFetch;
                end else if (tmo) begin
                    state_d = StFault;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        zflag_d = zflag_q;
        if (acc_ld) zflag_d = alu_zero;
    end

    assign zflag = zflag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zflag_q <= zflag_d;
        end
    end
endmodule

// File: tb/tb_risc8_ctrl.sv
// Directed bench for risc8_ctrl: per-cycle expected output vectors are queued as stimulus
// is applied and compared mid-cycle against the DUT.
module tb_risc8_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] instr;
    logic       alu_zero;
    logic       ir_ld, opnd_ld, pc_inc, pc_ld, acc_ld;
    logic [3:0] alu_op;
    logic       zflag, halted, fault;

    risc8_ctrl_if bus ();

    risc8_ctrl #(
        .ACK_TMO (15),
        .OPC_W   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .instr    (instr),
        .alu_zero (alu_zero),
        .bus      (bus),
        .ir_ld    (ir_ld),
        .opnd_ld  (opnd_ld),
        .pc_inc   (pc_inc),
        .pc_ld    (pc_ld),
        .acc_ld   (acc_ld),
        .alu_op   (alu_op),
        .zflag    (zflag),
        .halted   (halted),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector: {rd, wr, addr_sel, ir_ld, opnd_ld, pc_inc, pc_ld, acc_ld, alu_op[3:0], z, halt, flt}
    localparam logic [14:0] RD   = 15'h4000;
    localparam logic [14:0] WR   = 15'h2000;
    localparam logic [14:0] AS   = 15'h1000;
    localparam logic [14:0] IRL  = 15'h0800;
    localparam logic [14:0] OPL  = 15'h0400;
    localparam logic [14:0] PCI  = 15'h0200;
    localparam logic [14:0] PCL  = 15'h0100;
    localparam logic [14:0] ACL  = 15'h0080;
    localparam logic [14:0] Z    = 15'h0004;
    localparam logic [14:0] HLTD = 15'h0002;
    localparam logic [14:0] FLT  = 15'h0001;

    logic [14:0] exp_q[$];
    int          n_assert;
    int          n_fail;

    function automatic logic [14:0] aop(input int unsigned op);
        return 15'(op) << 3;
    endfunction

    task automatic check(input string tag);
        logic [14:0] obs;
        logic [14:0] exp_v;
        obs   = {bus.mem_rd, bus.mem_wr, bus.addr_sel, ir_ld, opnd_ld, pc_inc, pc_ld, acc_ld,
                 alu_op, zflag, halted, fault};
        exp_v = exp_q.pop_front();
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input string tag, input logic st, input logic [7:0] ins,
                        input logic ack, input logic az, input logic [14:0] exp_v);
        @(posedge clk);
        #1;
        start        = st;
        instr        = ins;
        bus.mem_ack  = ack;
        alu_zero     = az;
        exp_q.push_back(exp_v);
        #3;
        check(tag);
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        instr       = 8'h00;
        bus.mem_ack = 1'b0;
        alu_zero    = 1'b0;

        step("reset", 0, 8'h00, 0, 0, 15'h0);
        #1 rst_n = 1'b1;
        step("idle", 0, 8'h00, 0, 0, 15'h0);

        // Reset while waiting on an operand read.
        step("r_start", 1, 8'h00, 0, 0, 15'h0);
        step("r_fetch", 0, 8'h1A, 1, 0, RD | IRL);
        step("r_dec", 0, 8'h1A, 0, 0, PCI);
        step("r_oprd0", 0, 8'h1A, 0, 0, RD | AS);
        step("r_oprd1", 0, 8'h1A, 0, 0, RD | AS);
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(15'h0);
        check("rst_mid");
        #2 rst_n = 1'b1;
        step("r_idle", 0, 8'h1A, 0, 0, 15'h0);

        // ADD 0x1A: ir_ld c0, pc_inc c1, opnd_ld c2, alu_op=ADD & acc_ld c3.
        step("add_start", 1, 8'h00, 0, 0, 15'h0);
        step("add_c0", 0, 8'h1A, 1, 0, RD | IRL);
        step("add_c1", 0, 8'h1A, 0, 0, PCI);
        step("add_c2", 0, 8'h1A, 1, 0, RD | AS | OPL);
        step("add_c3", 0, 8'h1A, 0, 0, ACL | aop(1));

        // SUB giving zero sets zflag.
        step("sub_f", 0, 8'h23, 1, 0, RD | IRL);
        step("sub_d", 0, 8'h23, 0, 0, PCI);
        step("sub_o", 0, 8'h23, 1, 0, RD | AS | OPL);
        step("sub_x", 0, 8'h23, 0, 1, ACL | aop(2));

        // SKZ with zflag set: two pc_inc pulses.
        step("skz1_f", 0, 8'h80, 1, 0, RD | IRL | Z);
        step("skz1_d", 0, 8'h80, 0, 0, PCI | Z);
        step("skz1_s", 0, 8'h80, 0, 0, PCI | Z);

        // LDA of a nonzero operand: alu_op stays NOP, zflag clears.
        step("lda_f", 0, 8'h5F, 1, 0, RD | IRL | Z);
        step("lda_d", 0, 8'h5F, 0, 0, PCI | Z);
        step("lda_o", 0, 8'h5F, 1, 0, RD | AS | OPL | Z);
        step("lda_x", 0, 8'h5F, 0, 0, ACL | aop(0) | Z);

        // SKZ with zflag clear: single pc_inc.
        step("skz0_f", 0, 8'h80, 1, 0, RD | IRL);
        step("skz0_d", 0, 8'h80, 0, 0, PCI);

        // NOT of 0xFF yields zero.
        step("not_f", 0, 8'h4F, 1, 0, RD | IRL);
        step("not_d", 0, 8'h4F, 0, 0, PCI);
        step("not_x", 0, 8'h4F, 0, 1, ACL | aop(4));

        // JMP 0x7C: pc_ld without pc_inc, then straight to FETCH.
        step("jmp_f", 0, 8'h7C, 1, 0, RD | IRL | Z);
        step("jmp_d", 0, 8'h7C, 0, 0, PCL | Z);

        // Undefined opcode 0xC behaves as NOP.
        step("c_f", 0, 8'hC3, 1, 0, RD | IRL | Z);
        step("c_d", 0, 8'hC3, 0, 0, PCI | Z);

        // STO with ack delayed 5 cycles: mem_wr held 6 cycles.
        step("sto_f", 0, 8'h65, 1, 0, RD | IRL | Z);
        step("sto_d", 0, 8'h65, 0, 0, PCI | Z);
        for (int i = 0; i < 5; i++) step("sto_wait", 0, 8'h65, 0, 0, WR | AS | Z);
        step("sto_ack", 0, 8'h65, 1, 0, WR | AS | Z);

        // Fetch never acked: 15 cycles of mem_rd, then FAULT with strobes low.
        for (int i = 0; i < 15; i++) step("tmo_wait", 0, 8'h65, 0, 0, RD | Z);
        step("fault0", 0, 8'h65, 0, 0, FLT | Z);
        step("fault1", 0, 8'h65, 1, 0, FLT | Z);
        step("flt_start", 1, 8'h65, 0, 0, FLT | Z);

        // HLT 0x90: halted, no strobes for 20 cycles.
        step("hlt_f", 0, 8'h90, 1, 0, RD | IRL | Z);
        step("hlt_d", 0, 8'h90, 0, 0, PCI | Z);
        for (int i = 0; i < 20; i++) step("halt", 0, 8'h90, i[0], 0, HLTD | Z);
        step("hlt_start", 1, 8'h90, 0, 0, HLTD | Z);

        // Ack on the 15th waiting cycle wins over the timeout.
        for (int i = 0; i < 14; i++) step("late_wait", 0, 8'h00, 0, 0, RD | Z);
        step("late_ack", 0, 8'h00, 1, 0, RD | IRL | Z);
        step("late_dec", 0, 8'h00, 0, 0, PCI | Z);
        step("late_next", 0, 8'h00, 0, 0, RD | Z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
